// File: rtl/fsm_arbiter_rr.sv
// N-channel request/grant arbiter: fixed-priority or round-robin selection,
// bounded hold time with forced revocation, and an encoded grant index.
module fsm_arbiter_rr #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IW       = $clog2(N)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          mode_i,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic          gnt_valid_o,
   output logic [IW-1:0] gnt_id_o,
   output logic          timeout_o
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   state_e        state_q;
   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] gnt_id_q;
   logic [N-1:0]  gnt_q;
   logic [N-1:0]  skip_mask_q;
   logic [HW-1:0] hold_cnt_q;
   logic          gnt_valid_q;
   logic          timeout_q;

   logic [N-1:0]  unmasked;
   logic [N-1:0]  cand;
   logic [IW-1:0] win_id_d;
   logic          hold_limit;
   int            idx;

   // A previously revoked owner is passed over only while someone else is asking.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      unmasked = req_i & ~skip_mask_q;
      cand     = (|unmasked) ? unmasked : req_i;
      win_id_d = '0;
      idx      = 0;
      if (!mode_i) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) win_id_d = IW'(i);
         end
      end else begin
         // Scan from farthest to nearest so the first hit after rr_ptr wins.
         for (int k = N; k >= 1; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (cand[idx]) win_id_d = IW'(idx);
         end
      end
   end

   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));

   always_ff @(posedge clock_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= IW'(N - 1);
         gnt_id_q    <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         skip_mask_q <= '0;
         hold_cnt_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req_i) begin
                  state_q     <= GRANT;
                  gnt_q       <= {{(N-1){1'b0}}, 1'b1} << win_id_d;
                  gnt_id_q    <= win_id_d;
                  gnt_valid_q <= 1'b1;
                  rr_ptr_q    <= win_id_d;
                  hold_cnt_q  <= HW'(1);
                  skip_mask_q <= '0;
               end
            end
            GRANT: begin
               // Release takes precedence over the hold limit.
               if (!req_i[gnt_id_q]) begin
                  state_q     <= IDLE;
                  gnt_q       <= '0;
                  gnt_id_q    <= '0;
                  gnt_valid_q <= 1'b0;
                  hold_cnt_q  <= '0;
               end else if (hold_limit) begin
                  state_q     <= IDLE;
                  gnt_q       <= '0;
                  gnt_id_q    <= '0;
                  gnt_valid_q <= 1'b0;
                  hold_cnt_q  <= '0;
                  timeout_q   <= 1'b1;
                  skip_mask_q <= gnt_q;
               end else if (hold_cnt_q != '1) begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = gnt_valid_q;
   assign gnt_id_o    = gnt_id_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Self-checking bench for fsm_arbiter_rr: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_fsm_arbiter_rr;

   localparam int N  = 4;
   localparam int MH = 8;
   localparam int IW = $clog2(N);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          mode  = 1'b0;
   logic [N-1:0]  req   = '0;
   logic [N-1:0]  gnt;
   logic          gnt_valid;
   logic [IW-1:0] gnt_id;
   logic          timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: current owner (-1 = none), last winner, cycles held, skipped channel.
   int           m_owner = -1;
   int           m_ptr   = N - 1;
   int           m_hold  = 0;
   logic [N-1:0] m_skip  = '0;
   bit           m_to    = 1'b0;

   fsm_arbiter_rr #(.N(N), .MAX_HOLD(MH)) dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .mode_i      (mode),
      .req_i       (req),
      .gnt_o       (gnt),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id),
      .timeout_o   (timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] sk,
                               input logic md, input int ptr);
      logic [N-1:0] c;
      int           id;
      c = ((r & ~sk) != '0) ? (r & ~sk) : r;
      for (int k = 1; k <= N; k++) begin
         id = md ? (ptr + k) % N : k - 1;
         if (c[id]) return id;
      end
      return -1;
   endfunction

   task automatic model_update();
      int w;
      if (reset) begin
         m_owner = -1; m_ptr = N - 1; m_hold = 0; m_skip = '0; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            w = pick(req, m_skip, mode, m_ptr);
            if (w >= 0) begin
               m_owner = w; m_ptr = w; m_hold = 1; m_skip = '0;
            end
         end else if (!req[m_owner]) begin
            m_owner = -1; m_hold = 0;
         end else if (MH != 0 && m_hold == MH) begin
            m_skip  = '0;
            m_skip[m_owner] = 1'b1;
            m_to    = 1'b1;
            m_owner = -1; m_hold = 0;
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic compare();
      check("gnt",       int'(gnt),       (m_owner >= 0) ? (1 << m_owner) : 0);
      check("gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      check("gnt_id",    int'(gnt_id),    (m_owner >= 0) ? m_owner : 0);
      check("timeout",   int'(timeout),   int'(m_to));
   endtask

   // One clock: model and DUT see the same inputs at the edge, outputs sampled 1 ns later.
   task automatic step();
      @(posedge clock);
      model_update();
      #1;
      compare();
   endtask

   task automatic count_hold(input logic [N-1:0] pat, output int cnt);
      bit done;
      cnt  = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (gnt == pat) cnt++;
         else done = 1'b1;
      end
   endtask

   initial begin
      int      cnt;
      int      age;
      bit      prev_valid;
      int      order[$];
      int      exp_order[5] = '{0, 1, 2, 3, 0};

      // Reset, then a single request.
      reset = 1'b1; req = '0; mode = 1'b0;
      step(); step();
      check("reset_gnt", int'(gnt), 0);
      check("reset_id",  int'(gnt_id), 0);
      reset = 1'b0; req = 4'b0001;
      step();
      check("single_gnt", int'(gnt), 4'b0001);
      check("single_id",  int'(gnt_id), 0);
      req = 4'b0000;
      step();
      check("single_release", int'(gnt), 0);
      check("single_no_timeout", int'(timeout), 0);

      // Fixed priority and handoff dead cycle.
      req = 4'b1010;
      step();
      check("fixed_gnt", int'(gnt), 4'b0010);
      req = 4'b1000;
      step();
      check("handoff_gap", int'(gnt), 0);
      step();
      check("handoff_next", int'(gnt), 4'b1000);
      check("handoff_id",   int'(gnt_id), 3);
      req = '0;
      step();

      // Hold limit with a competing requester.
      req = 4'b0011;
      count_hold(4'b0001, cnt);
      check("hold_len", cnt, MH);
      check("timeout_pulse", int'(timeout), 1);
      step();
      check("skip_gnt", int'(gnt), 4'b0010);
      check("timeout_one_cycle", int'(timeout), 0);
      req = 4'b0001;
      step();
      check("skip_release", int'(gnt), 0);
      step();
      check("after_skip_gnt", int'(gnt), 4'b0001);
      req = '0;
      step(); step();

      // Sole requester regains the grant after its own revocation.
      req = 4'b0100;
      count_hold(4'b0100, cnt);
      check("sole_hold_len", cnt, MH);
      check("sole_timeout", int'(timeout), 1);
      step();
      check("sole_regrant", int'(gnt), 4'b0100);

      // Reset mid-grant in round-robin mode (owner 2, rr_ptr 2).
      mode = 1'b1;
      step();
      reset = 1'b1;
      step();
      check("midreset_gnt", int'(gnt), 0);
      check("midreset_valid", int'(gnt_valid), 0);
      reset = 1'b0; req = 4'b1111;
      step();
      check("postreset_gnt", int'(gnt), 4'b0001);
      req = '0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Round-robin: each agent drops its request two cycles after being granted.
      mode = 1'b1; req = 4'b1111; age = 0; prev_valid = 1'b0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         step();
         if (gnt_valid && !prev_valid) begin
            order.push_back(int'(gnt_id));
            age = 0;
         end
         if (gnt_valid) begin
            age++;
            if (age == 2) req[gnt_id] = 1'b0;
         end else begin
            req = 4'b1111;
         end
         prev_valid = gnt_valid;
      end
      check("rr_grants", order.size(), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);
      req = '0;
      step(); step();

      // Randomized traffic: sticky requests so revocations happen, occasional reset.
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
